cmb_vec_drv: RTL

stimulus-side partner of the cmb combinational benchmark. Assembles 16-bit input vectors from a byte stream, drives cmb inputs a..p, waits a settle time, samples the 4 responses q..t, returns them as a byte stream.

Interface
REQ-001 Parameter SETTLE, default 2: cycles between vector apply and response sample (0..15).
REQ-002 Parameter DEPTH, default 4: response FIFO entries (power of two, >=2).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  byte available on in_data.
REQ-006 in_ready  output  1  block accepts byte this cycle.
REQ-007 in_data  input  8  vector byte, low byte first.
REQ-008 vec  output  16  cmb inputs; vec[0]=a ... vec[15]=p.
REQ-009 rsp  input  4  cmb outputs {t,s,r,q}.
REQ-010 out_valid  output  1  response byte available.
REQ-011 out_ready  input  1  consumer accepts response byte.
REQ-012 out_data  output  8  {seq[3:0], rsp}.
REQ-013 busy  output  1  high when state is not GET_LO.

Function
REQ-014 Handshakes SHALL transfer only on valid&ready; in_ready SHALL be 1 in GET_LO and GET_HI, 0 otherwise.
REQ-015 GET_LO: on transfer, store in_data as the low byte and go to GET_HI.
REQ-016 GET_HI: on transfer, register vec={in_data,low byte} and load the settle counter with SETTLE; go to SETTLE, or directly to SAMPLE if SETTLE=0.
REQ-017 SETTLE: decrement the counter each cycle; go to SAMPLE on the cycle the counter equals 1 (exactly SETTLE cycles in SETTLE).
REQ-018 SAMPLE: if the FIFO is not full at cycle start, push {seq,rsp}, increment seq, and go to GET_LO; otherwise stay and re-sample rsp each cycle until the push occurs.
REQ-019 vec SHALL hold its value until the next GET_HI transfer.
REQ-020 seq SHALL be 4 bits and wrap from 15 to 0.
REQ-021 The FIFO SHALL support one push and one pop in the same cycle when neither full nor empty; a full FIFO SHALL NOT accept a push in the cycle it pops (no bypass).
REQ-022 out_valid = FIFO not empty; out_data SHALL equal the head entry, and 0x00 when empty.
REQ-023 Latency SHALL be 1 + SETTLE cycles from the GET_HI transfer to the push, when the FIFO is not full.

Reset
REQ-024 While rst_n=0: state=GET_LO, vec=0x0000, seq=0, FIFO empty, settle counter=0, in_ready=1, out_valid=0, out_data=0x00, busy=0.
REQ-025 Reset asserted mid-operation SHALL discard any partial vector and all FIFO contents.

Configuration
REQ-026 Macro CMB_VEC_DRV_STATS_EN defined: add output vec_count (8 bits), reset to 0, incremented on each FIFO push and saturating at 255.
REQ-027 Macro CMB_VEC_DRV_STATS_EN undefined: the vec_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (bench connects vec/rsp to the cmb benchmark)
REQ-028 Bytes 0x00,0x00 after reset, out_ready=1 -> vec=0x0000, out_data=0x0A exactly 1+SETTLE cycles after the second transfer.
REQ-029 Then bytes 0xFF,0x0F -> vec=0x0FFF, out_data=0x17 (seq=1, rsp=0x7).
REQ-030 out_ready=0, five vectors sent with DEPTH=4 -> four entries queued, block held in SAMPLE with busy=1 and in_ready=0; raising out_ready -> fifth entry is pushed one cycle after the first pop, and all five are delivered in order.
REQ-031 17 vectors sent -> the seq field wraps; the 17th response carries seq=0.
REQ-032 rst_n pulsed low after only the low byte is sent -> vec=0x0000, out_valid=0, and the next two bytes form a complete new vector.
REQ-033 With CMB_VEC_DRV_STATS_EN, 260 vectors sent -> vec_count=255 (saturated).

---
 rtl/cmb_vec_drv.sv | 113 +++++++++++
 1 files changed

// File: rtl/cmb_vec_drv.sv
// Byte-stream driver for the cmb benchmark: collects two-byte vectors, drives them, samples the
// 4-bit response after SETTLE cycles and queues {seq, rsp} bytes. Optional macro: CMB_VEC_DRV_STATS_EN.
module cmb_vec_drv #(
  parameter int SETTLE = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [15:0] vec,
  input  logic [3:0]  rsp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy
`ifdef CMB_VEC_DRV_STATS_EN
  ,
  output logic [7:0]  vec_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {GET_LO, GET_HI, SETTLE_ST, SAMPLE} state_t;

  state_t         state_reg, state_next;
  logic [7:0]     lo_reg;
  logic [15:0]    vec_reg;
  logic [3:0]     cnt_reg;
  logic [3:0]     seq_reg;
  logic [AW:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    used;
  logic [7:0]     mem [DEPTH];
  logic           full, empty, push, pop, in_xfer;

  assign used     = wr_ptr_reg - rd_ptr_reg;
  assign full     = (used == (AW+1)'(DEPTH));
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign in_xfer  = in_valid && in_ready;
  // Full is judged on the registered pointers, so a pop never frees a slot for the same cycle.
  assign push     = (state_reg == SAMPLE) && !full;
  assign pop      = !empty && out_ready;

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
  assign vec       = vec_reg;
  assign busy      = (state_reg != GET_LO);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      GET_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_next = GET_HI;
      end
      GET_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (SETTLE == 0) ? SAMPLE : SETTLE_ST;
      end
      SETTLE_ST: begin
        if (cnt_reg == 4'd1) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (!full) state_next = GET_LO;
      end
      default: state_next = GET_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= GET_LO;
      lo_reg     <= 8'h00;
      vec_reg    <= 16'h0000;
      cnt_reg    <= 4'd0;
      seq_reg    <= 4'd0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == GET_LO && in_xfer) lo_reg <= in_data;
      if (state_reg == GET_HI && in_xfer) begin
        vec_reg <= {in_data, lo_reg};
        cnt_reg <= 4'(SETTLE);
      end else if (state_reg == SETTLE_ST) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        seq_reg    <= seq_reg + 4'd1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {seq_reg, rsp};
  end

`ifdef CMB_VEC_DRV_STATS_EN
  logic [7:0] vec_count_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            vec_count_reg <= 8'd0;
    else if (push && vec_count_reg != 8'hFF) vec_count_reg <= vec_count_reg + 8'd1;
  end
  assign vec_count = vec_count_reg;
`endif

endmodule
